sdram_rw_cmd: RTL and testbench

//  SDRAM-side responder for the FIFO controller's burst read/write request handshake.

---
 rtl/sdram_rw_cmd.sv | 138 +++++++++++++
 tb/tb_sdram_rw_cmd.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_cmd.sv
// sdram_rw_cmd: arbitrates FIFO burst requests and drives ACT/RD|WR/BTERM/PRE on the SDRAM bus
module sdram_rw_cmd #(
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int CAS_LAT = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        aref_busy,
    input  logic        sdram_wr_req,
    input  logic [22:0] sdram_wr_addr,
    input  logic [9:0]  wr_burst_len,
    input  logic [15:0] sdram_in_data,
    output logic        sdram_wr_ack,
    input  logic        sdram_rd_req,
    input  logic [22:0] sdram_rd_addr,
    input  logic [9:0]  rd_burst_len,
    output logic [15:0] sdram_out_data,
    output logic        sdram_rd_ack,
    output logic        rw_busy,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    input  logic [15:0] sdram_dq_in
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] ACT     = 4'd1;
    localparam logic [3:0] TRCD    = 4'd2;
    localparam logic [3:0] WRITE   = 4'd3;
    localparam logic [3:0] READ    = 4'd4;
    localparam logic [3:0] RD_WAIT = 4'd5;
    localparam logic [3:0] TERM    = 4'd6;
    localparam logic [3:0] PRE     = 4'd7;
    localparam logic [3:0] TRP     = 4'd8;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_BTERM = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    logic [3:0]  state;
    logic [9:0]  cnt;
    logic [9:0]  len;
    logic        is_wr;
    logic [1:0]  bank;
    logic [11:0] row;
    logic [8:0]  col;
    logic        start;
    logic [9:0]  req_len;
    logic [9:0]  clip_len;
    logic [22:0] req_addr;
    logic [3:0]  burst_state;
    logic        last;
    logic        issue_rw;
    logic        rd_phase;

    // request arbitration (write wins) and burst-length clamping to one full page
    always_comb begin
        start       = init_end && !aref_busy && (sdram_wr_req || sdram_rd_req);
        req_len     = sdram_wr_req ? wr_burst_len : rd_burst_len;
        req_addr    = sdram_wr_req ? sdram_wr_addr : sdram_rd_addr;
        clip_len    = req_len == 10'd0 ? 10'd1 : req_len > 10'd512 ? 10'd512 : req_len;
        burst_state = is_wr ? WRITE : READ;
        last        = cnt == len - 10'd1;
    end

    // sequencer; cnt restarts at the RD/WR command and keeps running through the read drain
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            cnt   <= 10'd0;
            len   <= 10'd0;
            is_wr <= 1'b0;
            bank  <= 2'd0;
            row   <= 12'd0;
            col   <= 9'd0;
        end else begin
            cnt <= cnt + 10'd1;
            case (state)
                IDLE: begin
                    cnt <= 10'd0;
                    if (start) begin
                        state             <= ACT;
                        is_wr             <= sdram_wr_req;
                        {bank, row, col}  <= req_addr;
                        len               <= clip_len;
                    end
                end
                ACT: begin
                    cnt   <= 10'd0;
                    state <= T_RCD > 1 ? TRCD : burst_state;
                end
                TRCD: if (cnt == 10'(T_RCD - 2)) begin
                    cnt   <= 10'd0;
                    state <= burst_state;
                end
                WRITE, READ: if (last) state <= TERM;
                TERM: state <= is_wr ? PRE : RD_WAIT;
                RD_WAIT: if (cnt == len + 10'(CAS_LAT)) state <= PRE;
                PRE: begin
                    cnt   <= 10'd0;
                    state <= TRP;
                end
                TRP: if (cnt == 10'(T_RP - 1)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // read data is registered once; the ack window lines up with that register stage
    always_ff @(posedge sys_clk) begin
        sdram_out_data <= (sys_rst || !init_end) ? 16'd0 : sdram_dq_in;
    end

    // command/address decode and FIFO handshakes from the sequencer position
    always_comb begin
        issue_rw     = (state == WRITE || state == READ) && cnt == 10'd0;
        rd_phase     = !is_wr && (state == READ || state == TERM || state == RD_WAIT);
        sdram_cmd    = state == ACT ? CMD_ACT :
                       issue_rw ? (is_wr ? CMD_WR : CMD_RD) :
                       state == TERM ? CMD_BTERM :
                       state == PRE ? CMD_PRE : CMD_NOP;
        sdram_ba     = (state == ACT || issue_rw || state == PRE) ? bank : 2'd0;
        sdram_addr   = state == ACT ? {1'b0, row} : issue_rw ? {4'b0, col} : 13'd0;
        sdram_wr_ack = is_wr && ((state == ACT && T_RCD == 1) ||
                                 (state == TRCD && cnt == 10'(T_RCD - 2)) ||
                                 (state == WRITE && !last));
        sdram_rd_ack = rd_phase && cnt > 10'(CAS_LAT) && cnt <= len + 10'(CAS_LAT);
        sdram_dq_oe  = state == WRITE;
        sdram_dq_out = sdram_dq_oe ? sdram_in_data : 16'd0;
        rw_busy      = state != IDLE;
    end
endmodule

// File: tb/tb_sdram_rw_cmd.sv
// tb_sdram_rw_cmd: directed and randomized checks of the SDRAM read/write command sequencer
module tb_sdram_rw_cmd;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int CAS   = 3;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101;
    localparam logic [3:0] WR = 4'b0100, BT = 4'b0110, PRE = 4'b0010;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        wr_ack;
        logic        rd_ack;
        logic        oe;
        logic        busy;
    } exp_t;

    logic        sys_clk = 0, sys_rst = 1, init_end = 0, aref_busy = 0;
    logic        wr_req = 0, rd_req = 0;
    logic [22:0] wr_addr = 0, rd_addr = 0;
    logic [9:0]  wr_len = 0, rd_len = 0;
    logic [15:0] in_data = 0, dq_in = 0;
    logic        sdram_wr_ack, sdram_rd_ack, rw_busy, sdram_dq_oe;
    logic [15:0] sdram_out_data, sdram_dq_out;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    int          n_checks = 0, n_pass = 0;

    sdram_rw_cmd #(.T_RCD(T_RCD), .T_RP(T_RP), .CAS_LAT(CAS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .aref_busy(aref_busy),
        .sdram_wr_req(wr_req), .sdram_wr_addr(wr_addr), .wr_burst_len(wr_len),
        .sdram_in_data(in_data), .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_req(rd_req), .sdram_rd_addr(rd_addr), .rd_burst_len(rd_len),
        .sdram_out_data(sdram_out_data), .sdram_rd_ack(sdram_rd_ack), .rw_busy(rw_busy),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .sdram_dq_in(dq_in)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge sys_clk);
        #2;
    endtask

    function automatic int clip(input int n);
        return n == 0 ? 1 : n > 512 ? 512 : n;
    endfunction

    // expected bus view k cycles after the accept cycle, straight from the timing rules
    function automatic exp_t model(input bit wr, input int l, input logic [22:0] a, input int k);
        exp_t e;
        int t, pre;
        t = 1 + T_RCD;
        pre = wr ? t + l + 1 : t + CAS + l + 1;
        e = '0;
        e.cmd = NOP;
        if (k == 1) begin
            e.cmd = ACT; e.ba = a[22:21]; e.addr = {1'b0, a[20:9]};
        end else if (k == t) begin
            e.cmd = wr ? WR : RD; e.ba = a[22:21]; e.addr = {4'b0, a[8:0]};
        end else if (k == t + l) begin
            e.cmd = BT;
        end else if (k == pre) begin
            e.cmd = PRE; e.ba = a[22:21];
        end
        e.wr_ack = wr && k >= T_RCD && k <= T_RCD + l - 1;
        e.oe     = wr && k >= t && k < t + l;
        e.rd_ack = !wr && k > t + CAS && k <= t + CAS + l;
        e.busy   = k < pre + 1 + T_RP;
        return e;
    endfunction

    // drives one request from IDLE and measures acks, RD/WR commands and cycles to idle
    task automatic run_count(input bit wr, input logic [22:0] a, input logic [9:0] l,
                             output int acks, output int nrw, output logic [12:0] rw_addr,
                             output int cycles);
        acks = 0; nrw = 0; rw_addr = 0; cycles = -1;
        if (wr) begin wr_addr = a; wr_len = l; wr_req = 1; end
        else begin rd_addr = a; rd_len = l; rd_req = 1; end
        for (int k = 1; k <= 800 && cycles < 0; k++) begin
            tick;
            wr_req = 0; rd_req = 0; dq_in = 16'($urandom);
            acks += int'(wr ? sdram_wr_ack : sdram_rd_ack);
            if (sdram_cmd == WR || sdram_cmd == RD) begin nrw++; rw_addr = sdram_addr; end
            if (!rw_busy) cycles = k;
        end
    endtask

    task automatic test_reset;
        sys_rst = 1; init_end = 1; wr_req = 1; rd_req = 1; dq_in = 16'hFFFF; in_data = 16'h1234;
        repeat (3) tick;
        n_checks++;
        if ({sdram_cmd, sdram_ba, sdram_addr, sdram_wr_ack, sdram_rd_ack, sdram_dq_oe, rw_busy,
             sdram_dq_out, sdram_out_data} !== {NOP, 2'b0, 13'b0, 4'b0, 32'b0})
            $display("FAIL reset got cmd=%b ba=%0d addr=%h acks=%b%b oe=%b busy=%b dq=%h od=%h exp idle/zero",
                     sdram_cmd, sdram_ba, sdram_addr, sdram_wr_ack, sdram_rd_ack, sdram_dq_oe,
                     rw_busy, sdram_dq_out, sdram_out_data);
        else n_pass++;
        wr_req = 0; rd_req = 0; sys_rst = 0;
        tick;
        n_checks++;
        if ({sdram_cmd, rw_busy} !== {NOP, 1'b0})
            $display("FAIL reset_release got cmd=%b busy=%b exp %b 0", sdram_cmd, rw_busy, NOP);
        else n_pass++;
    endtask

    task automatic test_write_example;
        logic [3:0] ec;
        wr_addr = 23'h202434; wr_len = 10'd4; wr_req = 1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            wr_req = 0; in_data = 16'($urandom);
            #1;
            ec = k == 1 ? ACT : k == 3 ? WR : k == 7 ? BT : k == 8 ? PRE : NOP;
            n_checks++;
            if ({sdram_cmd, sdram_wr_ack, sdram_dq_oe, rw_busy} !== {ec, k >= 2 && k <= 5, k >= 3 && k <= 6, k < 11})
                $display("FAIL wr_ex c%0d got cmd=%b ack=%b oe=%b busy=%b exp cmd=%b", k, sdram_cmd,
                         sdram_wr_ack, sdram_dq_oe, rw_busy, ec);
            else n_pass++;
            if (k == 1 || k == 3) begin
                n_checks++;
                if ({sdram_ba, sdram_addr} !== {2'd1, k == 1 ? 13'h012 : 13'h034})
                    $display("FAIL wr_ex_addr c%0d got ba=%0d addr=%h", k, sdram_ba, sdram_addr);
                else n_pass++;
            end
            if (k >= 3 && k <= 6) begin
                n_checks++;
                if (sdram_dq_out !== in_data)
                    $display("FAIL wr_ex_dq c%0d got %h exp %h", k, sdram_dq_out, in_data);
                else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if ({sdram_ba, sdram_addr[10]} !== {2'd1, 1'b0})
                    $display("FAIL wr_ex_pre got ba=%0d a10=%b exp 1 0", sdram_ba, sdram_addr[10]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_read_example;
        logic [3:0] ec;
        rd_addr = 23'h202434; rd_len = 10'd4; rd_req = 1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            rd_req = 0;
            dq_in = (k >= 6 && k <= 9) ? 16'(16'hA0 + k - 6) : 16'($urandom);
            #1;
            ec = k == 1 ? ACT : k == 3 ? RD : k == 7 ? BT : k == 11 ? PRE : NOP;
            n_checks++;
            if ({sdram_cmd, sdram_rd_ack, sdram_wr_ack, sdram_dq_oe, rw_busy} !== {ec, k >= 7 && k <= 10, 2'b0, k < 14})
                $display("FAIL rd_ex c%0d got cmd=%b rd_ack=%b wr_ack=%b oe=%b busy=%b exp cmd=%b", k,
                         sdram_cmd, sdram_rd_ack, sdram_wr_ack, sdram_dq_oe, rw_busy, ec);
            else n_pass++;
            if (k >= 7 && k <= 10) begin
                n_checks++;
                if (sdram_out_data !== 16'(16'hA0 + k - 7))
                    $display("FAIL rd_ex_data c%0d got %h exp %h", k, sdram_out_data, 16'(16'hA0 + k - 7));
                else n_pass++;
            end
        end
    endtask

    task automatic test_priority;
        logic [3:0] ec;
        wr_addr = 23'h4A1234; wr_len = 10'd4; rd_addr = 23'h7F0055; rd_len = 10'd2;
        wr_req = 1; rd_req = 1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            wr_req = 0;
            ec = k == 1 ? ACT : k == 3 ? WR : k == 7 ? BT : k == 8 ? PRE : NOP;
            n_checks++;
            if ({sdram_cmd, rw_busy} !== {ec, k < 11})
                $display("FAIL prio_wr c%0d got cmd=%b busy=%b exp cmd=%b", k, sdram_cmd, rw_busy, ec);
            else n_pass++;
        end
        for (int k = 1; k <= 12; k++) begin
            tick;
            rd_req = 0;
            ec = k == 1 ? ACT : k == 3 ? RD : k == 5 ? BT : k == 9 ? PRE : NOP;
            n_checks++;
            if ({sdram_cmd, rw_busy} !== {ec, k < 12})
                $display("FAIL prio_rd c%0d got cmd=%b busy=%b exp cmd=%b", k, sdram_cmd, rw_busy, ec);
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if ({sdram_ba, sdram_addr} !== {2'd3, 13'h0F80})
                    $display("FAIL prio_rd_act got ba=%0d addr=%h exp 3 0f80", sdram_ba, sdram_addr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_len_clip;
        int acks, nrw, cyc;
        logic [12:0] ra;
        run_count(1'b1, 23'h415610, 10'd0, acks, nrw, ra, cyc);
        n_checks++;
        if (acks !== 1 || cyc !== 3 + T_RCD + 1 + T_RP)
            $display("FAIL len0_wr got acks=%0d cycles=%0d exp 1 %0d", acks, cyc, 3 + T_RCD + 1 + T_RP);
        else n_pass++;
        run_count(1'b1, 23'h000100, 10'd600, acks, nrw, ra, cyc);
        n_checks++;
        if (acks !== 512 || cyc !== 3 + T_RCD + 512 + T_RP)
            $display("FAIL len600_wr got acks=%0d cycles=%0d exp 512 %0d", acks, cyc, 3 + T_RCD + 512 + T_RP);
        else n_pass++;
        run_count(1'b1, {2'd3, 12'h123, 9'h1FE}, 10'd4, acks, nrw, ra, cyc);
        n_checks++;
        if (acks !== 4 || nrw !== 1 || ra !== 13'h1FE)
            $display("FAIL wrap_wr got acks=%0d wr_cmds=%0d addr=%h exp 4 1 1fe", acks, nrw, ra);
        else n_pass++;
        run_count(1'b0, 23'h1ABCDE, 10'd0, acks, nrw, ra, cyc);
        n_checks++;
        if (acks !== 1 || cyc !== 3 + T_RCD + CAS + 1 + T_RP)
            $display("FAIL len0_rd got acks=%0d cycles=%0d exp 1 %0d", acks, cyc, 3 + T_RCD + CAS + 1 + T_RP);
        else n_pass++;
        run_count(1'b0, 23'h0000F0, 10'd513, acks, nrw, ra, cyc);
        n_checks++;
        if (acks !== 512 || nrw !== 1 || cyc !== 3 + T_RCD + CAS + 512 + T_RP)
            $display("FAIL len513_rd got acks=%0d rd_cmds=%0d cycles=%0d exp 512 1 %0d", acks, nrw, cyc,
                     3 + T_RCD + CAS + 512 + T_RP);
        else n_pass++;
    endtask

    task automatic test_hold_off;
        wr_addr = 23'h100200; wr_len = 10'd2; wr_req = 1; rd_req = 1; rd_len = 10'd2;
        aref_busy = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin aref_busy = 0; init_end = 0; end
            tick;
            dq_in = 16'($urandom);
            n_checks++;
            if ({sdram_cmd, sdram_wr_ack, sdram_rd_ack, rw_busy} !== {NOP, 3'b0})
                $display("FAIL hold c%0d got cmd=%b acks=%b%b busy=%b exp NOP idle", k, sdram_cmd,
                         sdram_wr_ack, sdram_rd_ack, rw_busy);
            else n_pass++;
            if (k >= 6) begin
                n_checks++;
                if (sdram_out_data !== 16'd0)
                    $display("FAIL hold_od c%0d got %h exp 0", k, sdram_out_data);
                else n_pass++;
            end
        end
        init_end = 1;
        tick;
        wr_req = 0; rd_req = 0;
        n_checks++;
        if ({sdram_cmd, rw_busy} !== {ACT, 1'b1})
            $display("FAIL hold_release got cmd=%b busy=%b exp %b 1", sdram_cmd, rw_busy, ACT);
        else n_pass++;
        for (int k = 0; k < 60 && rw_busy; k++) tick;
        for (int k = 0; k < 60 && rw_busy; k++) tick;
        n_checks++;
        if (rw_busy !== 1'b0)
            $display("FAIL hold_drain got busy=%b exp 0", rw_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        wr_addr = 23'h3FFE00; wr_len = 10'd8; wr_req = 1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            wr_req = 0;
        end
        n_checks++;
        if ({sdram_dq_oe, rw_busy} !== 2'b11)
            $display("FAIL rst_mid_pre got oe=%b busy=%b exp 1 1", sdram_dq_oe, rw_busy);
        else n_pass++;
        sys_rst = 1;
        tick;
        sys_rst = 0;
        n_checks++;
        if ({sdram_cmd, sdram_wr_ack, sdram_dq_oe, rw_busy} !== {NOP, 3'b0})
            $display("FAIL rst_mid got cmd=%b ack=%b oe=%b busy=%b exp NOP 0 0 0", sdram_cmd,
                     sdram_wr_ack, sdram_dq_oe, rw_busy);
        else n_pass++;
        tick;
        n_checks++;
        if ({sdram_cmd, rw_busy} !== {NOP, 1'b0})
            $display("FAIL rst_mid_after got cmd=%b busy=%b exp NOP 0", sdram_cmd, rw_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random(input int n);
        exp_t e;
        bit wr;
        int l, r, t, idle;
        logic [22:0] a;
        logic [9:0] raw;
        logic [15:0] q[$];
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom);
            a = 23'($urandom);
            r = $urandom_range(0, 9);
            raw = r == 0 ? 10'd0 : r == 1 ? 10'($urandom_range(513, 1023)) : 10'($urandom_range(1, 24));
            l = clip(int'(raw));
            t = 1 + T_RCD;
            idle = wr ? 3 + T_RCD + l + T_RP : 3 + T_RCD + CAS + l + T_RP;
            q.delete();
            if (wr) begin wr_addr = a; wr_len = raw; wr_req = 1; end
            else begin rd_addr = a; rd_len = raw; rd_req = 1; end
            for (int k = 1; k <= idle; k++) begin
                tick;
                wr_req = 0; rd_req = 0;
                in_data = 16'($urandom); dq_in = 16'($urandom);
                if (!wr && k >= t + CAS && k < t + CAS + l) q.push_back(dq_in);
                #1;
                e = model(wr, l, a, k);
                n_checks++;
                if ({sdram_cmd, sdram_wr_ack, sdram_rd_ack, sdram_dq_oe, rw_busy} !==
                    {e.cmd, e.wr_ack, e.rd_ack, e.oe, e.busy})
                    $display("FAIL rnd_ctl txn%0d k=%0d got=%h exp=%h", i, k,
                             {sdram_cmd, sdram_wr_ack, sdram_rd_ack, sdram_dq_oe, rw_busy},
                             {e.cmd, e.wr_ack, e.rd_ack, e.oe, e.busy});
                else n_pass++;
                if (e.cmd == ACT || e.cmd == RD || e.cmd == WR) begin
                    n_checks++;
                    if ({sdram_ba, sdram_addr} !== {e.ba, e.addr})
                        $display("FAIL rnd_addr txn%0d k=%0d got ba=%0d addr=%h exp ba=%0d addr=%h", i, k,
                                 sdram_ba, sdram_addr, e.ba, e.addr);
                    else n_pass++;
                end
                if (e.oe) begin
                    n_checks++;
                    if (sdram_dq_out !== in_data)
                        $display("FAIL rnd_dq txn%0d k=%0d got %h exp %h", i, k, sdram_dq_out, in_data);
                    else n_pass++;
                end
                if (e.rd_ack) begin
                    w = q.size() > 0 ? q.pop_front() : 16'hxxxx;
                    n_checks++;
                    if (sdram_out_data !== w)
                        $display("FAIL rnd_rdata txn%0d k=%0d got %h exp %h", i, k, sdram_out_data, w);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_example;
        test_read_example;
        test_priority;
        test_len_clip;
        test_hold_off;
        test_reset_mid_write;
        test_back_to_back_random(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
